// File: rtl/mem_pkg.sv
// mem_pkg: size codes, responder FSM encoding and lane constants shared by the data-memory path
`timescale 1ns/1ps
package mem_pkg;
    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HWORD = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_ILL   = 2'b11;
    localparam int LANE_W = 8;
    localparam int HALF_W = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane logic, store merge into an old word and load extract with extension
`timescale 1ns/1ps
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    output logic [31:0] o_merged,
    output logic [31:0] o_extracted
);
    logic [4:0] w_byte_base;
    logic [4:0] w_half_base;
    logic [LANE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;
    assign w_byte_base = {i_off, 3'b000};
    assign w_half_base = {i_off[1], 4'b0000};
    assign w_byte = i_word[w_byte_base +: LANE_W];
    assign w_half = i_word[w_half_base +: HALF_W];
    always_comb begin
        o_merged = i_word;
        if (i_size == SIZE_BYTE)
            o_merged[w_byte_base +: LANE_W] = i_wdata[LANE_W-1:0];
        else if (i_size == SIZE_HWORD)
            o_merged[w_half_base +: HALF_W] = i_wdata[HALF_W-1:0];
        else
            o_merged = i_wdata;
    end
    assign o_extracted = (i_size == SIZE_BYTE)  ? {{(32-LANE_W){~i_unsigned & w_byte[LANE_W-1]}}, w_byte} :
                         (i_size == SIZE_HWORD) ? {{(32-HALF_W){~i_unsigned & w_half[HALF_W-1]}}, w_half} :
                         i_word;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready load/store responder over a word-organized synchronous SRAM,
// with read-modify-write for sub-word stores and sign/zero-extended loads.
`timescale 1ns/1ps
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WORD_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_we,
    input  logic                  req_unsigned,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t r_state, w_next;
    logic [AW-1:0]         r_idx;
    logic [1:0]            r_off;
    logic [1:0]            r_size;
    logic                  r_we;
    logic                  r_unsigned;
    logic                  r_err;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [WORD_WIDTH-1:0] r_rdword;
    logic [WORD_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_WIDTH-1:0] w_merged;
    logic [WORD_WIDTH-1:0] w_extracted;
    logic                  w_accept;
    logic                  w_req_err;
    assign req_ready = (r_state == ST_IDLE) & rst;
    assign w_accept  = req_valid & req_ready;
    assign w_req_err = (req_size == SIZE_ILL) |
                       ((req_size == SIZE_HWORD) & req_addr[0]) |
                       ((req_size == SIZE_WORD) & (|req_addr[1:0])) |
                       ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = rsp_valid & r_err;
    assign rsp_rdata = (rsp_valid & ~r_we & ~r_err) ? w_extracted : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept)
                          w_next = w_req_err ? ST_RESP :
                                   (req_we && req_size == SIZE_WORD) ? ST_WRITE : ST_READ;
            ST_READ:  w_next = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE: w_next = ST_RESP;
            ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx      <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_idx      <= req_addr[AW+1:2];
            r_off      <= req_addr[1:0];
            r_size     <= req_size;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_err      <= w_req_err;
            r_wdata    <= req_wdata;
        end
    end
    // WRITE is only reachable with rst high; the async clear of r_state drops a pending write
    always_ff @(posedge clk) begin
        if (r_state == ST_WRITE)
            r_mem[r_idx] <= w_merged;
        if (r_state == ST_READ)
            r_rdword <= r_mem[r_idx];
    end
    mem_lane_align u_align (
        .i_word      (r_rdword),
        .i_wdata     (r_wdata),
        .i_size      (r_size),
        .i_off       (r_off),
        .i_unsigned  (r_unsigned),
        .o_merged    (w_merged),
        .o_extracted (w_extracted)
    );
endmodule
